// File: rtl/mc6502_pkg.sv
// mc6502_pkg: shared definitions for the 6502 shift/rotate sequencer.
//   - op encoding: bit1 = right, bit0 = rotate
//   - sequencer state enum
//   - bus direction constants for o_rw
package mc6502_pkg;

  localparam logic [1:0] OP_ASL = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_LSR = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_READ   = 2'd1,
    ST_DWRITE = 2'd2,
    ST_WRITE  = 2'd3
  } state_e;

endpackage

// File: rtl/MC6502Shifter.sv
// MC6502Shifter: combinational 8-bit shift/rotate unit.
//   i_rotate  1  shift i_c in instead of 0
//   i_right   1  shift direction (1 = right)
//   i_c       1  carry-in
//   i_data    8  operand
//   o_data    8  shifted value
//   o_n/o_z/o_c  result flags (carry = bit shifted out)
module MC6502Shifter (
  input  logic       i_rotate,
  input  logic       i_right,
  input  logic       i_c,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  output logic       o_n,
  output logic       o_z,
  output logic       o_c
);

  logic fill;

  always_comb begin
    fill = i_rotate & i_c;
    if (i_right) begin
      o_data = {fill, i_data[7:1]};
      o_c    = i_data[0];
    end else begin
      o_data = {i_data[6:0], fill};
      o_c    = i_data[7];
    end
    o_n = o_data[7];
    o_z = (o_data == 8'h00);
  end

endmodule

// File: rtl/mc6502_shift_sequencer.sv
// mc6502_shift_sequencer: runs ASL/ROL/LSR/ROR in accumulator form (no bus
// cycles, 1-cycle latency) or read-modify-write form (read, dummy write of
// the original value, final write of the result).
//   clk, rst_x        clock, async active-low reset
//   i_start, i_op, i_acc, i_a, i_addr, i_c   request (sampled in IDLE)
//   i_rdy, i_rdata    bus ready (stalls reads only) and read data
//   o_addr, o_rw, o_wdata   bus address, direction (1 = read), write data
//   o_busy            high in READ/DWRITE/WRITE
//   o_done            one-cycle completion pulse
//   o_result, o_n, o_z, o_c  result and flags, held until next completion
module mc6502_shift_sequencer
  import mc6502_pkg::*;
(
  input  logic        clk,
  input  logic        rst_x,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic        i_acc,
  input  logic [7:0]  i_a,
  input  logic [15:0] i_addr,
  input  logic        i_c,
  input  logic        i_rdy,
  input  logic [7:0]  i_rdata,
  output logic [15:0] o_addr,
  output logic        o_rw,
  output logic [7:0]  o_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [7:0]  o_result,
  output logic        o_n,
  output logic        o_z,
  output logic        o_c
);

  state_e      state_q;
  logic [15:0] addr_q;
  logic [7:0]  operand_q;
  logic [1:0]  op_q;
  logic        c_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic        done_q;
  logic [7:0]  result_q;
  logic        n_q, z_q, cf_q;

  logic        idle;
  logic [7:0]  sh_in;
  logic [1:0]  sh_op;
  logic        sh_cin;
  logic [7:0]  sh_out;
  logic        sh_n, sh_z, sh_c;

  // In IDLE the shifter sees the live request (accumulator form completes
  // from it directly); otherwise it works on the latched memory operand.
  assign idle   = (state_q == ST_IDLE);
  assign sh_in  = idle ? i_a  : operand_q;
  assign sh_op  = idle ? i_op : op_q;
  assign sh_cin = idle ? i_c  : c_q;

  MC6502Shifter u_shifter (
    .i_rotate (sh_op[0]),
    .i_right  (sh_op[1]),
    .i_c      (sh_cin),
    .i_data   (sh_in),
    .o_data   (sh_out),
    .o_n      (sh_n),
    .o_z      (sh_z),
    .o_c      (sh_c)
  );

  always_ff @(posedge clk or negedge rst_x) begin
    if (!rst_x) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      operand_q <= '0;
      op_q      <= '0;
      c_q       <= 1'b0;
      rw_q      <= RW_READ;
      wdata_q   <= '0;
      done_q    <= 1'b0;
      result_q  <= '0;
      n_q       <= 1'b0;
      z_q       <= 1'b0;
      cf_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_start) begin
            if (i_acc) begin
              result_q <= sh_out;
              n_q      <= sh_n;
              z_q      <= sh_z;
              cf_q     <= sh_c;
              done_q   <= 1'b1;
            end else begin
              addr_q  <= i_addr;
              op_q    <= i_op;
              c_q     <= i_c;
              rw_q    <= RW_READ;
              state_q <= ST_READ;
            end
          end
        end
        ST_READ: begin
          if (i_rdy) begin
            // Dummy write puts the unmodified value back on the bus.
            operand_q <= i_rdata;
            wdata_q   <= i_rdata;
            rw_q      <= RW_WRITE;
            state_q   <= ST_DWRITE;
          end
        end
        ST_DWRITE: begin
          wdata_q <= sh_out;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          result_q <= sh_out;
          n_q      <= sh_n;
          z_q      <= sh_z;
          cf_q     <= sh_c;
          done_q   <= 1'b1;
          rw_q     <= RW_READ;
          state_q  <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_addr   = addr_q;
  assign o_rw     = rw_q;
  assign o_wdata  = wdata_q;
  assign o_busy   = !idle;
  assign o_done   = done_q;
  assign o_result = result_q;
  assign o_n      = n_q;
  assign o_z      = z_q;
  assign o_c      = cf_q;

endmodule

// File: tb/tb_mc6502_shift_sequencer.sv
// Testbench for mc6502_shift_sequencer: expected bus cycles and completions
// are queued when a request is driven; a negedge monitor pops and compares
// each observed read, write and done pulse, including the cycle it lands in.
module tb_mc6502_shift_sequencer;

  localparam int EV_NONE  = 0;
  localparam int EV_READ  = 1;
  localparam int EV_WRITE = 2;
  localparam int EV_DONE  = 3;

  typedef struct {
    int         kind;
    int         cyc;
    logic [15:0] addr;
    logic [7:0]  data;
    logic [2:0]  nzc;
  } ev_t;

  logic        clk;
  logic        rst_x;
  logic        i_start;
  logic [1:0]  i_op;
  logic        i_acc;
  logic [7:0]  i_a;
  logic [15:0] i_addr;
  logic        i_c;
  logic        i_rdy;
  logic [7:0]  i_rdata;
  logic [15:0] o_addr;
  logic        o_rw;
  logic [7:0]  o_wdata;
  logic        o_busy;
  logic        o_done;
  logic [7:0]  o_result;
  logic        o_n, o_z, o_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  ev_t sb[$];

  mc6502_shift_sequencer dut (
    .clk      (clk),
    .rst_x    (rst_x),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_acc    (i_acc),
    .i_a      (i_a),
    .i_addr   (i_addr),
    .i_c      (i_c),
    .i_rdy    (i_rdy),
    .i_rdata  (i_rdata),
    .o_addr   (o_addr),
    .o_rw     (o_rw),
    .o_wdata  (o_wdata),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_n      (o_n),
    .o_z      (o_z),
    .o_c      (o_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Reference shift: returns {carry, result}.
  function automatic logic [8:0] ref_shift(input logic [1:0] op, input logic [7:0] d,
                                           input logic cin);
    logic [8:0] r;
    case (op)
      2'b00:   r = {d[7], d[6:0], 1'b0};
      2'b01:   r = {d[7], d[6:0], cin};
      2'b10:   r = {d[0], 1'b0, d[7:1]};
      default: r = {d[0], cin, d[7:1]};
    endcase
    return r;
  endfunction

  function automatic logic [2:0] ref_flags(input logic [8:0] r);
    return {r[7], (r[7:0] == 8'h00), r[8]};
  endfunction

  task automatic push_ev(input int kind, input int c, input logic [15:0] a,
                         input logic [7:0] dat, input logic [2:0] f);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    e.addr = a;
    e.data = dat;
    e.nzc  = f;
    sb.push_back(e);
  endtask

  task automatic observe(input int kind, input logic [15:0] a, input logic [7:0] dat,
                         input logic [2:0] f);
    ev_t e;
    if (sb.size() == 0) begin
      e.kind = EV_NONE;
      e.cyc  = -1;
      e.addr = '0;
      e.data = '0;
      e.nzc  = '0;
    end else begin
      e = sb.pop_front();
    end
    check("ev_kind", kind, e.kind);
    check("ev_cycle", cyc, e.cyc);
    if (kind != EV_DONE) check("bus_addr", {16'h0, a}, {16'h0, e.addr});
    if (kind == EV_WRITE) check("bus_wdata", {24'h0, dat}, {24'h0, e.data});
    if (kind == EV_DONE) begin
      check("result", {24'h0, dat}, {24'h0, e.data});
      check("flags_nzc", {29'h0, f}, {29'h0, e.nzc});
    end
  endtask

  always @(negedge clk) begin
    if (rst_x) begin
      if (o_busy && o_rw && i_rdy) observe(EV_READ, o_addr, 8'h00, 3'b000);
      if (!o_rw) observe(EV_WRITE, o_addr, o_wdata, 3'b000);
      if (o_done) observe(EV_DONE, 16'h0000, o_result, {o_n, o_z, o_c});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic scramble();
    i_acc  = 1'($urandom);
    i_op   = 2'($urandom);
    i_addr = 16'($urandom);
    i_c    = 1'($urandom);
    i_a    = 8'($urandom);
  endtask

  // Accumulator form; returns in the done cycle so a follow-up start is back-to-back.
  task automatic acc_op(input logic [1:0] op, input logic [7:0] a, input logic cin);
    logic [8:0] r;
    r = ref_shift(op, a, cin);
    i_start = 1'b1; i_acc = 1'b1; i_op = op; i_a = a; i_c = cin;
    i_addr = 16'($urandom); i_rdy = 1'($urandom); i_rdata = 8'($urandom);
    push_ev(EV_DONE, cyc + 1, 16'h0, r[7:0], ref_flags(r));
    step();
    i_start = 1'b0;
    check("acc_busy", {31'h0, o_busy}, 32'h0);
  endtask

  // Memory form with a number of stalled READ cycles; optionally pulses a
  // conflicting start during DWRITE. Returns in the done cycle.
  task automatic mem_op(input logic [1:0] op, input logic [15:0] addr, input logic cin,
                        input logic [7:0] rdata, input int stalls, input bit dw_start);
    logic [8:0] r;
    int d;
    r = ref_shift(op, rdata, cin);
    d = cyc;
    i_start = 1'b1; i_acc = 1'b0; i_op = op; i_addr = addr; i_c = cin;
    i_a = 8'($urandom); i_rdy = 1'($urandom); i_rdata = 8'($urandom);
    push_ev(EV_READ,  d + 1 + stalls, addr, 8'h00, 3'b000);
    push_ev(EV_WRITE, d + 2 + stalls, addr, rdata, 3'b000);
    push_ev(EV_WRITE, d + 3 + stalls, addr, r[7:0], 3'b000);
    push_ev(EV_DONE,  d + 4 + stalls, 16'h0, r[7:0], ref_flags(r));
    step();
    i_start = 1'b0;
    scramble();
    check("read_busy", {31'h0, o_busy}, 32'h1);
    for (int s = 0; s < stalls; s++) begin
      i_rdy = 1'b0; i_rdata = 8'($urandom);
      step();
    end
    i_rdy = 1'b1; i_rdata = rdata;
    step();
    i_rdy = (stalls > 0) ? 1'b0 : 1'($urandom);
    i_rdata = 8'($urandom);
    if (dw_start) begin
      i_start = 1'b1; i_acc = 1'b0; i_addr = addr ^ 16'hFFFF;
    end
    step();
    i_start = 1'b0;
    step();
    check("done_busy", {31'h0, o_busy}, 32'h0);
  endtask

  initial begin
    rst_x = 1'b0; i_start = 1'b0; i_op = '0; i_acc = 1'b0; i_a = '0;
    i_addr = '0; i_c = 1'b0; i_rdy = 1'b1; i_rdata = '0;
    step();
    step();
    check("rst_rw", {31'h0, o_rw}, 32'h1);
    check("rst_addr", {16'h0, o_addr}, 32'h0);
    check("rst_wdata", {24'h0, o_wdata}, 32'h0);
    check("rst_busy", {31'h0, o_busy}, 32'h0);
    check("rst_done", {31'h0, o_done}, 32'h0);
    check("rst_result", {24'h0, o_result}, 32'h0);
    check("rst_flags", {29'h0, o_n, o_z, o_c}, 32'h0);
    rst_x = 1'b1;
    step();

    acc_op(2'b00, 8'h80, 1'b0);
    acc_op(2'b01, 8'h41, 1'b1);
    step();
    check("hold_done", {31'h0, o_done}, 32'h0);
    check("hold_result", {24'h0, o_result}, 32'h83);
    check("hold_flags", {29'h0, o_n, o_z, o_c}, 32'h4);

    mem_op(2'b11, 16'h1234, 1'b1, 8'h01, 0, 1'b0);
    mem_op(2'b10, 16'h0200, 1'b0, 8'h02, 2, 1'b0);
    mem_op(2'b00, 16'h3456, 1'b0, 8'hC3, 0, 1'b1);
    mem_op(2'b01, 16'hABCD, 1'b1, 8'h7F, 1, 1'b0);

    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0)
        acc_op(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom));
      else
        mem_op(2'($urandom_range(0, 3)), 16'($urandom), 1'($urandom), 8'($urandom),
               $urandom_range(0, 2), 1'($urandom));
    end

    // Leave non-zero flags/result so the reset abort has something to clear.
    mem_op(2'b11, 16'h0F0F, 1'b1, 8'h01, 0, 1'b0);
    i_start = 1'b1; i_acc = 1'b0; i_op = 2'b11; i_addr = 16'h2000; i_c = 1'b0;
    push_ev(EV_READ, cyc + 1, 16'h2000, 8'h00, 3'b000);
    step();
    i_start = 1'b0; i_rdy = 1'b1; i_rdata = 8'h03;
    step();
    check("dw_rw", {31'h0, o_rw}, 32'h0);
    rst_x = 1'b0;
    #1;
    check("abort_rw", {31'h0, o_rw}, 32'h1);
    check("abort_busy", {31'h0, o_busy}, 32'h0);
    check("abort_done", {31'h0, o_done}, 32'h0);
    check("abort_result", {24'h0, o_result}, 32'h0);
    check("abort_flags", {29'h0, o_n, o_z, o_c}, 32'h0);
    step();
    step();
    rst_x = 1'b1;
    step();
    step();
    check("post_rst_busy", {31'h0, o_busy}, 32'h0);
    check("post_rst_flags", {29'h0, o_n, o_z, o_c}, 32'h0);
    step();
    check("sb_empty", sb.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
